// File: rtl/dht11_responder_pkg.sv
// Shared DHT11 protocol definitions: FSM state encoding, phase timing in
// microseconds, frame geometry and the checksum helper. Used by the
// responder and by host-side receiver logic.
package dht11_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOST_LOW,
      ST_TGO,
      ST_RESP_LOW,
      ST_RESP_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_END_LOW
   } state_t;

   localparam int unsigned RESP_LOW_US  = 80;
   localparam int unsigned RESP_HIGH_US = 80;
   localparam int unsigned BIT_LOW_US   = 50;
   localparam int unsigned BIT0_HIGH_US = 26;
   localparam int unsigned BIT1_HIGH_US = 70;
   localparam int unsigned END_LOW_US   = 50;
   localparam int unsigned FRAME_BITS   = 40;
   localparam int unsigned BIT_CNT_W    = 6;
   localparam int unsigned TIMER_W      = 16;
   // Ticks ignored at the start of a released phase while the bus
   // climbs back through the synchronizer.
   localparam int unsigned SETTLE_US    = 2;

   // 8-bit modulo-256 sum of the four payload bytes.
   function automatic logic [7:0] dht11_checksum(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] c,
                                                 input logic [7:0] d);
      logic [9:0] s;
      s = 10'(a) + 10'(b) + 10'(c) + 10'(d);
      return s[7:0];
   endfunction

endpackage

// File: rtl/dht11_frame_shifter.sv
// 40-bit frame register: latches payload plus checksum, shifts MSB first.
// Ports: clk, rst (async high), load (latch payload), shift (advance one
// bit), hum_int/hum_dec/tmp_int/tmp_dec (payload), bit_val (current bit).
module dht11_frame_shifter
   import dht11_responder_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] tmp_int,
   input  logic [7:0] tmp_dec,
   output logic       bit_val
);

   logic [FRAME_BITS-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= {hum_int, hum_dec, tmp_int, tmp_dec,
                dht11_checksum(hum_int, hum_dec, tmp_int, tmp_dec)};
      end else if (shift) begin
         sr <= {sr[FRAME_BITS-2:0], 1'b0};
      end
   end

   assign bit_val = sr[FRAME_BITS-1];

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects a host start request on the
// single-wire bus and answers with the response preamble and 40-bit frame.
// Ports: clk, rst (async high), dht_in (bus level), dht_oe (1 = pull low),
// hum_int/hum_dec/tmp_int/tmp_dec (payload), busy, frame_done (pulse),
// bus_err (pulse on contention abort).
module dht11_responder
   import dht11_responder_pkg::*;
#(
   parameter int unsigned CLK_PER_US   = 1,
   parameter int unsigned START_MIN_US = 18000,
   parameter int unsigned TGO_US       = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dht_in,
   output logic       dht_oe,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] tmp_int,
   input  logic [7:0] tmp_dec,
   output logic       busy,
   output logic       frame_done,
   output logic       bus_err
);

   localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   logic                 sync_0, sync_1, dht_prev;
   logic                 fall_c, rise_c;
   logic [PRE_W-1:0]     pre_cnt;
   logic                 tick_c;
   logic [TIMER_W-1:0]   us_cnt;
   logic                 lo_seen;
   logic [BIT_CNT_W-1:0] bit_cnt;
   state_t               state, state_d;
   int unsigned          dur_c;
   logic                 phase_chg_c, phase_end_c, host_ok_c, chk_c, contend_c;
   logic                 load_c, shift_c, abort_c, oe_d_c, busy_d_c;
   logic                 bit_val;

   // Two-flop synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_0   <= 1'b1;
         sync_1   <= 1'b1;
         dht_prev <= 1'b1;
      end else begin
         sync_0   <= dht_in;
         sync_1   <= sync_0;
         dht_prev <= sync_1;
      end
   end

   assign fall_c      = dht_prev & ~sync_1;
   assign rise_c      = ~dht_prev & sync_1;
   assign tick_c      = (pre_cnt == PRE_W'(CLK_PER_US - 1));
   assign phase_chg_c = (state_d != state);

   // Prescaler restarts on every state change so each phase is whole ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (phase_chg_c || tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Per-phase microsecond timer, saturating for long host lows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         us_cnt <= '0;
      end else if (phase_chg_c) begin
         us_cnt <= '0;
      end else if (tick_c && (us_cnt != '1)) begin
         us_cnt <= us_cnt + TIMER_W'(1);
      end
   end

   // Contention: bus low on two consecutive ticks while we are released.
   assign chk_c     = tick_c && ((state == ST_RESP_HIGH) || (state == ST_BIT_HIGH))
                      && (32'(us_cnt) >= SETTLE_US);
   assign contend_c = chk_c && !sync_1 && lo_seen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_seen <= 1'b0;
      end else if (phase_chg_c) begin
         lo_seen <= 1'b0;
      end else if (chk_c) begin
         lo_seen <= ~sync_1;
      end
   end

   // The tick landing on the release edge completes the host low time.
   assign host_ok_c   = (32'(us_cnt) + 32'(tick_c)) >= START_MIN_US;
   assign phase_end_c = tick_c && ((32'(us_cnt) + 32'd1) >= dur_c);

   // Phase length in microseconds for the current state.
   always_comb begin
      dur_c = 0;
      case (state)
         ST_TGO:       dur_c = TGO_US;
         ST_RESP_LOW:  dur_c = RESP_LOW_US;
         ST_RESP_HIGH: dur_c = RESP_HIGH_US;
         ST_BIT_LOW:   dur_c = BIT_LOW_US;
         ST_BIT_HIGH:  dur_c = bit_val ? BIT1_HIGH_US : BIT0_HIGH_US;
         ST_END_LOW:   dur_c = END_LOW_US;
         default:      dur_c = 0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
      end else if (load_c) begin
         bit_cnt <= '0;
      end else if (shift_c) begin
         bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
   end

   dht11_frame_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load    (load_c),
      .shift   (shift_c),
      .hum_int (hum_int),
      .hum_dec (hum_dec),
      .tmp_int (tmp_int),
      .tmp_dec (tmp_dec),
      .bit_val (bit_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic; falls are only acted on in IDLE, so our own
   // low pulses never restart the sequence.
   always_comb begin
      state_d = state;
      load_c  = 1'b0;
      shift_c = 1'b0;
      abort_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall_c) state_d = ST_HOST_LOW;
         end
         ST_HOST_LOW: begin
            if (rise_c) begin
               if (host_ok_c) begin
                  state_d = ST_TGO;
                  load_c  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_TGO: begin
            if (phase_end_c) state_d = ST_RESP_LOW;
         end
         ST_RESP_LOW: begin
            if (phase_end_c) state_d = ST_RESP_HIGH;
         end
         ST_RESP_HIGH: begin
            if (contend_c) begin
               state_d = ST_IDLE;
               abort_c = 1'b1;
            end else if (phase_end_c) begin
               state_d = ST_BIT_LOW;
            end
         end
         ST_BIT_LOW: begin
            if (phase_end_c) state_d = ST_BIT_HIGH;
         end
         ST_BIT_HIGH: begin
            if (contend_c) begin
               state_d = ST_IDLE;
               abort_c = 1'b1;
            end else if (phase_end_c) begin
               shift_c = 1'b1;
               state_d = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
            end
         end
         ST_END_LOW: begin
            if (phase_end_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign oe_d_c   = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) ||
                     (state_d == ST_END_LOW);
   assign busy_d_c = (state_d != ST_IDLE) && (state_d != ST_HOST_LOW);

   // Registered outputs track the next state so they align with it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dht_oe     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         dht_oe     <= oe_d_c;
         busy       <= busy_d_c;
         frame_done <= (state == ST_END_LOW) && (state_d == ST_IDLE);
         bus_err    <= abort_c;
      end
   end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: three instances (default 1 MHz, short start
// threshold at 1 MHz, and 25 clocks/us) driven by a host bus model.
module tb_dht11_responder;

   logic       clk = 1'b0;
   logic [2:0] rst_v;
   logic [2:0] host_low;
   wire  [2:0] oe, busy, fd, be;
   wire  [2:0] bus;
   logic [7:0] hi[3], hd[3], ti[3], td[3];

   int n_checks = 0;
   int n_err    = 0;
   int fd_cnt[3], be_cnt[3], busy_cnt[3], oe_cnt[3];

   always #5 clk = ~clk;

   // Open-drain bus with pull-up: low if either side pulls.
   assign bus = ~(oe | host_low);

   dht11_responder #(.CLK_PER_US(1), .START_MIN_US(18000), .TGO_US(30)) u_dut0 (
      .clk(clk), .rst(rst_v[0]), .dht_in(bus[0]), .dht_oe(oe[0]),
      .hum_int(hi[0]), .hum_dec(hd[0]), .tmp_int(ti[0]), .tmp_dec(td[0]),
      .busy(busy[0]), .frame_done(fd[0]), .bus_err(be[0]));

   dht11_responder #(.CLK_PER_US(1), .START_MIN_US(200), .TGO_US(30)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .dht_in(bus[1]), .dht_oe(oe[1]),
      .hum_int(hi[1]), .hum_dec(hd[1]), .tmp_int(ti[1]), .tmp_dec(td[1]),
      .busy(busy[1]), .frame_done(fd[1]), .bus_err(be[1]));

   dht11_responder #(.CLK_PER_US(25), .START_MIN_US(20), .TGO_US(30)) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .dht_in(bus[2]), .dht_oe(oe[2]),
      .hum_int(hi[2]), .hum_dec(hd[2]), .tmp_int(ti[2]), .tmp_dec(td[2]),
      .busy(busy[2]), .frame_done(fd[2]), .bus_err(be[2]));

   // Count high cycles of each pulse/status output.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (fd[k])   fd_cnt[k]++;
         if (be[k])   be_cnt[k]++;
         if (busy[k]) busy_cnt[k]++;
         if (oe[k])   oe_cnt[k]++;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int cpu_of(input int k);
      return (k == 2) ? 25 : 1;
   endfunction

   // Reference frame: four payload bytes then their sum modulo 256.
   function automatic logic [39:0] frame_model(input int h, input int hdv,
                                               input int t, input int tdv);
      int cs;
      cs = (h + hdv + t + tdv) % 256;
      return {8'(h), 8'(hdv), 8'(t), 8'(tdv), 8'(cs)};
   endfunction

   task automatic set_payload(input int k, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
      hi[k] = a; hd[k] = b; ti[k] = c; td[k] = d;
   endtask

   task automatic host_start(input int k, input int low_us);
      host_low[k] = 1'b1;
      repeat (low_us * cpu_of(k)) @(negedge clk);
      host_low[k] = 1'b0;
   endtask

   // Length in clocks of the run of dht_oe==lvl starting at this negedge.
   task automatic measure_run(input int k, input logic lvl, output int n);
      int cap;
      cap = 200 * cpu_of(k);
      n = 0;
      while (busy[k] && (oe[k] == lvl) && (n < cap)) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_frame(input int k, input logic [39:0] exp, input int nbits,
                            input bit chg);
      int c, n, cpu;
      logic [39:0] got;
      logic b;
      cpu = cpu_of(k);
      got = '0;
      c = 0;
      while (!busy[k] && (c < 1000)) begin
         @(negedge clk);
         c++;
      end
      check($sformatf("u%0d_start", k), int'(busy[k]), 1);
      if (chg) set_payload(k, ~hi[k], ~hd[k], hi[k] ^ 8'h5A, td[k] + 8'd77);
      measure_run(k, 1'b0, n); check($sformatf("u%0d_tgo", k), n, 30 * cpu);
      measure_run(k, 1'b1, n); check($sformatf("u%0d_resp_low", k), n, 80 * cpu);
      measure_run(k, 1'b0, n); check($sformatf("u%0d_resp_high", k), n, 80 * cpu);
      for (int i = 0; i < nbits; i++) begin
         measure_run(k, 1'b1, n);
         check($sformatf("u%0d_bit%0d_low", k, i), n, 50 * cpu);
         measure_run(k, 1'b0, n);
         b = exp[39-i];
         check($sformatf("u%0d_bit%0d_high", k, i), n, (b ? 70 : 26) * cpu);
         got[39-i] = (n > 48 * cpu);
      end
      if (nbits == 40) begin
         measure_run(k, 1'b1, n); check($sformatf("u%0d_end_low", k), n, 50 * cpu);
         check($sformatf("u%0d_end_busy", k), int'(busy[k]), 0);
         check($sformatf("u%0d_end_oe", k), int'(oe[k]), 0);
         check($sformatf("u%0d_end_done", k), int'(fd[k]), 1);
         for (int j = 0; j < 5; j++)
            check($sformatf("u%0d_byte%0d", k, j), int'(got[39-8*j -: 8]),
                  int'(exp[39-8*j -: 8]));
      end
   endtask

   initial begin
      logic [39:0] e;
      int f0, b0, o0, e0, c;
      host_low = '0;
      rst_v    = '1;
      for (int k = 0; k < 3; k++) set_payload(k, 8'd0, 8'd0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("u%0d_rst_oe", k), int'(oe[k]), 0);
         check($sformatf("u%0d_rst_busy", k), int'(busy[k]), 0);
         check($sformatf("u%0d_rst_done", k), int'(fd[k]), 0);
         check($sformatf("u%0d_rst_err", k), int'(be[k]), 0);
      end
      rst_v = '0;
      repeat (5) @(negedge clk);

      fork
         begin
            // Default threshold: one cycle short, then exact.
            b0 = busy_cnt[0]; o0 = oe_cnt[0];
            host_start(0, 17999);
            repeat (60) @(negedge clk);
            check("u0_short_busy", busy_cnt[0] - b0, 0);
            check("u0_short_oe", oe_cnt[0] - o0, 0);
            set_payload(0, 8'h37, 8'h00, 8'h19, 8'h05);
            f0 = fd_cnt[0];
            host_start(0, 18000);
            run_frame(0, frame_model(8'h37, 8'h00, 8'h19, 8'h05), 40, 1'b0);
            repeat (5) @(negedge clk);
            check("u0_done_once", fd_cnt[0] - f0, 1);
         end
         begin
            // 25 clocks/us with payload scrambled right after latching.
            set_payload(2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            e = frame_model(hi[2], hd[2], ti[2], td[2]);
            host_start(2, 25);
            run_frame(2, e, 12, 1'b1);
            rst_v[2] = 1'b1;
            #1;
            check("u2_rst_oe", int'(oe[2]), 0);
            @(negedge clk);
            rst_v[2] = 1'b0;
         end
      join

      // All-ones payload: checksum 0xFC, every data bit 70 us.
      repeat (20) @(negedge clk);
      set_payload(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      host_start(1, 250);
      run_frame(1, frame_model(255, 255, 255, 255), 40, 1'b0);

      // Random frames.
      for (int r = 0; r < 2; r++) begin
         repeat (20) @(negedge clk);
         set_payload(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         host_start(1, 200 + int'($urandom_range(0, 50)));
         run_frame(1, frame_model(hi[1], hd[1], ti[1], td[1]), 40, 1'b0);
      end

      // Host contention 10 us into the third data bit's high phase.
      repeat (20) @(negedge clk);
      set_payload(1, 8'($urandom) | 8'h20, 8'($urandom), 8'($urandom), 8'($urandom));
      f0 = fd_cnt[1]; e0 = be_cnt[1];
      host_start(1, 250);
      run_frame(1, frame_model(hi[1], hd[1], ti[1], td[1]), 2, 1'b0);
      measure_run(1, 1'b1, c);
      check("u1_abort_bit_low", c, 50);
      repeat (10) @(negedge clk);
      host_low[1] = 1'b1;
      c = 0;
      while (busy[1] && (c < 40)) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      check("u1_abort_busy", int'(busy[1]), 0);
      check("u1_abort_oe", int'(oe[1]), 0);
      check("u1_abort_err", be_cnt[1] - e0, 1);
      check("u1_abort_nodone", fd_cnt[1] - f0, 0);
      b0 = busy_cnt[1];
      host_low[1] = 1'b0;
      repeat (40) @(negedge clk);
      check("u1_abort_quiet", busy_cnt[1] - b0, 0);

      // Reset during bit 20, then a clean frame.
      set_payload(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      f0 = fd_cnt[1]; e0 = be_cnt[1];
      host_start(1, 250);
      run_frame(1, frame_model(hi[1], hd[1], ti[1], td[1]), 20, 1'b0);
      check("u1_pre_rst_oe", int'(oe[1]), 1);
      rst_v[1] = 1'b1;
      #1;
      check("u1_rst_oe", int'(oe[1]), 0);
      check("u1_rst_busy", int'(busy[1]), 0);
      @(negedge clk);
      rst_v[1] = 1'b0;
      repeat (20) @(negedge clk);
      check("u1_rst_nopulse", (fd_cnt[1] - f0) + (be_cnt[1] - e0), 0);
      set_payload(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      host_start(1, 220);
      run_frame(1, frame_model(hi[1], hd[1], ti[1], td[1]), 40, 1'b0);

      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
